bcd4_to_bin: RTL and testbench
==============================

BCD4_TO_BIN -- requirements
Module: bcd4_to_bin

Interface
- REQ-001 Parameter VW, default 14: width of the binary result. It SHALL be at least 14 so that 9999 fits.
- REQ-002 Port clk, input, 1 bit: the single clock. All state SHALL update on the rising edge of clk.
- REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
- REQ-004 Ports A, B, C, D, inputs, 4 bits each: BCD digits. A is thousands, B hundreds, C tens, D units.
- REQ-005 Port start, input, 1 bit: conversion request, sampled at a rising edge of clk.
- REQ-006 Port ready, output, 1 bit: high means idle and value is valid.
- REQ-007 Port value, output, VW bits: the binary result.
- REQ-008 Port err, output, 1 bit: invalid-digit flag for the last conversion.

Function
- REQ-009 The state machine SHALL have two states, IDLE and CONV, plus a 2-bit digit counter cnt.
- REQ-010 In IDLE, start=1 at a rising edge SHALL capture A-D into internal registers, clear the accumulator and cnt, deassert ready, and enter CONV.
- REQ-011 In CONV, each edge SHALL compute acc = acc*10 + digit[cnt], with A first, then B, C, D, and increment cnt.
- REQ-012 The multiply by 10 SHALL be implemented as (acc<<3)+(acc<<1), with VW-bit modulo arithmetic.
- REQ-013 On the 4th CONV edge (cnt=3), the block SHALL load value with the final sum, assert ready, update err, and return to IDLE.
- REQ-014 Latency: ready SHALL be low for exactly 4 cycles after the capture edge. ready=1 and the new value SHALL be visible immediately after capture edge + 4.
- REQ-015 start while in CONV SHALL be ignored, and the captured digits SHALL not change.
- REQ-016 value and err SHALL hold their last result while in IDLE and throughout CONV. They SHALL never show partial sums.
- REQ-017 start held high continuously SHALL start a new conversion on the first edge that finds the block in IDLE, giving back-to-back conversions every 5 cycles.
- REQ-018 Input digits SHALL be don't-care except at the capture edge.

Reset
- REQ-019 rst=1 at a rising edge SHALL force state=IDLE, cnt=0, acc=0, value=0, err=0 and ready=1.
- REQ-020 rst SHALL take priority over start and over an in-progress CONV. An aborted conversion SHALL produce no value update.

Configuration
- REQ-021 Macro BCD2BIN_CHECK_EN, when defined, SHALL enable digit validation. A captured digit greater than 9 SHALL set an error flag. On completion, err=1 and value=0. err SHALL clear on the next valid conversion.
- REQ-022 Without BCD2BIN_CHECK_EN, err SHALL be tied to 0, and digits greater than 9 SHALL be used arithmetically, modulo 2^VW.

Structure
- REQ-023 A shared package bcd_pkg SHALL hold:
  - the BCD digit width constant (4);
  - the digit count (4);
  - the state typedef (IDLE, CONV);
  - the constant TEN=10.
- REQ-024 The datapath step acc*10+digit SHALL be a combinational sub-module named bcd_mac10. The FSM, counter and registers SHALL stay in bcd4_to_bin.

Verification
- REQ-025 Scenario: A-D=0,0,3,6 with a 1-cycle start pulse. Expected: ready low for 4 cycles, then ready=1, value=36, err=0.
- REQ-026 Scenario: 9,9,9,9. Expected: value=9999. Then 0,0,0,0 gives value=0. Between conversions, value holds 9999 until the second completion.
- REQ-027 Scenario: start 1,2,3,4, then change the digits to 5,6,7,8 and pulse start during CONV. Expected: value=1234, and no second conversion starts.
- REQ-028 Scenario: rst asserted 2 cycles into a conversion of 4,3,2,1 after a previous result of 36. Expected: next cycle ready=1, value=0, err=0.
- REQ-029 Scenario: F,F,F,F with the macro defined. Expected: err=1, value=0. A following 0,0,3,6 gives err=0, value=36.
- REQ-030 Scenario: F,F,F,F without the macro, VW=14. Expected: value=281 (16665 mod 16384), err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// BCD2BIN_CHECK_EN (optional) enables digit validation in bcd4_to_bin.
package bcd_pkg;

   localparam int unsigned DIG_W = 4;
   localparam int unsigned N_DIG = 4;
   localparam int unsigned TEN   = 10;

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   function automatic logic digit_bad(input logic [DIG_W-1:0] d);
      return d >= DIG_W'(TEN);
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational datapath step: sum = acc*10 + digit, modulo 2^VW.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int unsigned VW = 14
) (
   input  logic [VW-1:0]    acc_i,
   input  logic [DIG_W-1:0] digit_i,
   output logic [VW-1:0]    sum_o
);

   always_comb begin
      sum_o = (acc_i << 3) + (acc_i << 1) + {{(VW-DIG_W){1'b0}}, digit_i};
   end

endmodule

// File: rtl/bcd4_to_bin.sv
// Sequential 4-digit BCD to binary converter, one digit per cycle.
// Define BCD2BIN_CHECK_EN to flag captured digits greater than 9.
module bcd4_to_bin
   import bcd_pkg::*;
#(
   parameter int unsigned VW = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIG_W-1:0] A,
   input  logic [DIG_W-1:0] B,
   input  logic [DIG_W-1:0] C,
   input  logic [DIG_W-1:0] D,
   input  logic             start,
   output logic             ready,
   output logic [VW-1:0]    value,
   output logic             err
);

   state_t                        state_q, state_d;
   logic [1:0]                    cnt_q, cnt_d;
   logic [VW-1:0]                 acc_q, acc_d;
   logic [VW-1:0]                 value_q, value_d;
   logic [N_DIG-1:0][DIG_W-1:0]   dig_q, dig_d;
   logic [VW-1:0]                 mac_sum;
`ifdef BCD2BIN_CHECK_EN
   logic                          bad_q, bad_d;
   logic                          err_q, err_d;
`endif

   bcd_mac10 #(.VW(VW)) u_mac (
      .acc_i   (acc_q),
      .digit_i (dig_q[cnt_q]),
      .sum_o   (mac_sum)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      value_d = value_q;
      dig_d   = dig_q;
`ifdef BCD2BIN_CHECK_EN
      bad_d   = bad_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               // A is consumed first, so it sits at index 0
               dig_d   = {D, C, B, A};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CONV;
`ifdef BCD2BIN_CHECK_EN
               bad_d   = digit_bad(A) | digit_bad(B) | digit_bad(C) | digit_bad(D);
`endif
            end
         end
         CONV: begin
            acc_d = mac_sum;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = IDLE;
`ifdef BCD2BIN_CHECK_EN
               value_d = bad_q ? '0 : mac_sum;
               err_d   = bad_q;
`else
               value_d = mac_sum;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         value_q <= '0;
         dig_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         dig_q   <= dig_d;
`ifdef BCD2BIN_CHECK_EN
         bad_q   <= bad_d;
         err_q   <= err_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign value = value_q;
`ifdef BCD2BIN_CHECK_EN
   assign err   = err_q;
`else
   assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd4_to_bin.sv
// Directed-vector bench for bcd4_to_bin; follows BCD2BIN_CHECK_EN if defined.
module tb_bcd4_to_bin;

   localparam int unsigned VW = 14;
`ifdef BCD2BIN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    A, B, C, D;
   logic          ready;
   logic          err;
   logic [VW-1:0] value;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd4_to_bin #(.VW(VW)) dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .start (start),
      .ready (ready),
      .value (value),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One conversion with a single-cycle start pulse; optionally disturbs digits/start mid-CONV.
   task automatic run(input logic [3:0] a, b, c, d,
                      input logic [31:0] old_val, input logic old_err,
                      input logic [31:0] exp_val, input logic exp_err,
                      input bit poke);
      @(negedge clk);
      A = a; B = b; C = c; D = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         A = 4'd5; B = 4'd6; C = 4'd7; D = 4'd8;
      end
      for (int i = 0; i < 4; i++) begin
         check("busy",      ready, 0);
         check("hold_val",  value, old_val);
         check("hold_err",  err,   old_err);
         start = (poke && i == 1);
         @(negedge clk);
      end
      start = 1'b0;
      check("done_rdy", ready, 1);
      check("done_val", value, exp_val);
      check("done_err", err,   exp_err);
      if (poke) begin
         @(negedge clk);
         check("no_restart", ready, 1);
         check("no_restart_val", value, exp_val);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_rdy", ready, 1);
      check("rst_val", value, 0);
      check("rst_err", err,   0);
      rst = 1'b0;

      run(4'd0, 4'd0, 4'd3, 4'd6,    0, 1'b0,   36, 1'b0, 1'b0);
      run(4'd9, 4'd9, 4'd9, 4'd9,   36, 1'b0, 9999, 1'b0, 1'b0);
      run(4'd0, 4'd0, 4'd0, 4'd0, 9999, 1'b0,    0, 1'b0, 1'b0);
      run(4'd1, 4'd2, 4'd3, 4'd4,    0, 1'b0, 1234, 1'b0, 1'b1);
      run(4'd0, 4'd0, 4'd3, 4'd6, 1234, 1'b0,   36, 1'b0, 1'b0);

      // reset in the middle of a 4,3,2,1 conversion
      @(negedge clk);
      A = 4'd4; B = 4'd3; C = 4'd2; D = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_busy", ready, 0);
      check("abort_hold", value, 36);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rdy", ready, 1);
      check("abort_val", value, 0);
      check("abort_err", err,   0);
      @(negedge clk);
      check("abort_idle", ready, 1);
      check("abort_noval", value, 0);

      run(4'hF, 4'hF, 4'hF, 4'hF, 0, 1'b0, CHK ? 0 : 281, CHK, 1'b0);
      run(4'd0, 4'd0, 4'd3, 4'd6, CHK ? 0 : 281, CHK, 36, 1'b0, 1'b0);

      // start held high: conversions every 5 cycles
      @(negedge clk);
      A = 4'd0; B = 4'd0; C = 4'd1; D = 4'd2;
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("b2b_rdy", ready, (k % 5 == 0) ? 1 : 0);
         if (k == 5) begin
            check("b2b_val1", value, 12);
            C = 4'd2; D = 4'd0;
         end
         if (k == 10) begin
            check("b2b_val2", value, 20);
            start = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_stop", ready, 1);
      check("b2b_final", value, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
